key_debounce_pulse: RTL and testbench

- Upstream conditioning stage for the board's push-buttons (KEY, active-low), feeding the counter/display chain with clean, clock-synchronous control.
- Per key: 2-flop synchroniser, debounce FSM, and registered one-cycle press/release/hold pulses plus a debounced level.
- Replaces direct use of raw KEY inputs as counter clear/enable.

---
 rtl/key_debounce_pulse.sv | 178 +++++++++++++++++
 tb/tb_key_debounce_pulse.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: conditions the board's active-low push-buttons.
// Each key has a two-flop synchroniser, a debounce FSM and a hold timer.
// The outputs are a debounced level and registered one-cycle press,
// release and hold pulses.
// The release pulse port is named `rel` because `release` is a reserved
// word in SystemVerilog.
// Optional feature: define KEY_AUTOREPEAT_EN to re-issue press pulses
// while a key stays held after its hold pulse.
module key_debounce_pulse #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] rel,
  output logic [N_KEYS-1:0] hold
);

  // Number of bits needed to hold the value v.
  function automatic int clogb2(input int v);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) > 1) w = i + 2;
    end
    return w;
  endfunction

  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CNT_W  = clogb2(MAX_C);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYCLES);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Increment that sticks at lim once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] key_s;

  // Stage p0/p1: two-flop synchroniser; reset to "released".
  always_ff @(posedge clk) begin
    if (!aclr) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  assign key_s = ~sync_p1;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_t           state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             level_r;
    logic             press_r;
    logic             rel_r;
    logic             hold_r;
    logic             held;
    logic             rel_done;
`ifdef KEY_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
`endif

    assign held     = (state == PRESSED) || (state == RELEASE_WAIT);
    // A release completing on this edge takes priority over hold and repeat.
    assign rel_done = (state == RELEASE_WAIT) && !key_s[k] && (deb_cnt == DEB_LAST);

    // Debounce FSM, hold timer and optional repeat timer; all outputs registered.
    always_ff @(posedge clk) begin
      if (!aclr) begin
        state    <= IDLE;
        deb_cnt  <= '0;
        hold_cnt <= '0;
        level_r  <= 1'b0;
        press_r  <= 1'b0;
        rel_r    <= 1'b0;
        hold_r   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_cnt  <= '0;
`endif
      end else begin
        press_r <= 1'b0;
        rel_r   <= 1'b0;
        hold_r  <= 1'b0;

        case (state)
          IDLE: begin
            if (key_s[k]) begin
              state   <= PRESS_WAIT;
              deb_cnt <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!key_s[k]) begin
              state <= IDLE;
            end else if (deb_cnt == DEB_LAST) begin
              state   <= PRESSED;
              press_r <= 1'b1;
              level_r <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          PRESSED: begin
            if (!key_s[k]) begin
              state   <= RELEASE_WAIT;
              deb_cnt <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (key_s[k]) begin
              state <= PRESSED;
            end else if (deb_cnt == DEB_LAST) begin
              state   <= IDLE;
              rel_r   <= 1'b1;
              level_r <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        // Hold timer runs while the key is debounced-pressed and
        // saturates at HOLD_CYCLES, so hold fires only once per press.
        if (!held || rel_done) begin
          hold_cnt <= '0;
        end else begin
          hold_cnt <= sat_inc(hold_cnt, HOLD_SAT);
          if (hold_cnt == HOLD_LAST) hold_r <= 1'b1;
        end

`ifdef KEY_AUTOREPEAT_EN
        // Repeat timer is armed once the hold timer has saturated.
        if (!held || rel_done || (hold_cnt != HOLD_SAT)) begin
          rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
          press_r <= 1'b1;
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
`endif
      end
    end

    assign level[k] = level_r;
    assign press[k] = press_r;
    assign rel[k]   = rel_r;
    assign hold[k]  = hold_r;
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10,
// REPEAT_CYCLES=3. Each scenario queues stimulus words {aclr, key_n[1:0]}.
// It also queues the expected pulse events at the cycle index where they
// must appear. The DUT output is compared every cycle against that
// scoreboard.
module tb_key_debounce_pulse;

  logic       clk = 1'b0;
  logic       aclr;
  logic [1:0] key_n;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] hold;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] hold;
    logic [1:0] level;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] stim[$];

  key_debounce_pulse #(
    .N_KEYS(2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .key_n(key_n),
    .level(level),
    .press(press),
    .rel(rel),
    .hold(hold)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_stim(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  task automatic ev(input int c, input logic [1:0] p, input logic [1:0] r,
                    input logic [1:0] h, input logic [1:0] l);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.hold = h; e.level = l;
    sb.push_back(e);
  endtask

  // Reset with key 0 held, then key 0 re-debounced after reset release.
  task automatic test_reset();
    logic [7:0] got, want;
    logic [1:0] lvl;
    exp_t       e;
    stim.delete(); sb.delete(); lvl = 2'b00;
    add_stim({1'b0, 2'b10}, 3);
    add_stim({1'b1, 2'b10}, 8);
    add_stim({1'b1, 2'b11}, 12);
    ev(9,  2'b01, 2'b00, 2'b00, 2'b01);
    ev(17, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < stim.size(); i++) begin
      {aclr, key_n} = stim[i];
      tick();
      got = {press, rel, hold, level};
      if (sb.size() != 0 && sb[0].cyc == i) begin
        e = sb.pop_front(); lvl = e.level;
        want = {e.press, e.rel, e.hold, e.level};
      end else want = {6'b0, lvl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset cyc=%0d prhl got=%b required=%b", i, got, want);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_pending got=%0d required=0", sb.size());
    end
  endtask

  // Clean press of key 0 held 8 cycles; key 1 untouched.
  task automatic test_clean_press();
    logic [7:0] got, want;
    logic [1:0] lvl;
    exp_t       e;
    stim.delete(); sb.delete(); lvl = 2'b00;
    add_stim({1'b1, 2'b11}, 2);
    add_stim({1'b1, 2'b10}, 8);
    add_stim({1'b1, 2'b11}, 12);
    ev(8,  2'b01, 2'b00, 2'b00, 2'b01);
    ev(16, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < stim.size(); i++) begin
      {aclr, key_n} = stim[i];
      tick();
      got = {press, rel, hold, level};
      if (sb.size() != 0 && sb[0].cyc == i) begin
        e = sb.pop_front(); lvl = e.level;
        want = {e.press, e.rel, e.hold, e.level};
      end else want = {6'b0, lvl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clean_press cyc=%0d prhl got=%b required=%b", i, got, want);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL clean_press_pending got=%0d required=0", sb.size());
    end
  endtask

  // Short glitch is rejected; a high blip restarts the debounce.
  task automatic test_glitch();
    logic [7:0] got, want;
    logic [1:0] lvl;
    exp_t       e;
    stim.delete(); sb.delete(); lvl = 2'b00;
    add_stim({1'b1, 2'b11}, 1);
    add_stim({1'b1, 2'b10}, 3);
    add_stim({1'b1, 2'b11}, 11);
    add_stim({1'b1, 2'b10}, 3);
    add_stim({1'b1, 2'b11}, 1);
    add_stim({1'b1, 2'b10}, 8);
    add_stim({1'b1, 2'b11}, 12);
    ev(25, 2'b01, 2'b00, 2'b00, 2'b01);
    ev(33, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < stim.size(); i++) begin
      {aclr, key_n} = stim[i];
      tick();
      got = {press, rel, hold, level};
      if (sb.size() != 0 && sb[0].cyc == i) begin
        e = sb.pop_front(); lvl = e.level;
        want = {e.press, e.rel, e.hold, e.level};
      end else want = {6'b0, lvl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL glitch cyc=%0d prhl got=%b required=%b", i, got, want);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL glitch_pending got=%0d required=0", sb.size());
    end
  endtask

  // Release bounce: one release pulse; the hold timer is not restarted.
  task automatic test_release_bounce();
    logic [7:0] got, want;
    logic [1:0] lvl;
    exp_t       e;
    stim.delete(); sb.delete(); lvl = 2'b00;
    add_stim({1'b1, 2'b10}, 8);
    add_stim({1'b1, 2'b11}, 1);
    add_stim({1'b1, 2'b10}, 1);
    add_stim({1'b1, 2'b11}, 1);
    add_stim({1'b1, 2'b10}, 1);
    add_stim({1'b1, 2'b11}, 12);
    ev(6,  2'b01, 2'b00, 2'b00, 2'b01);
    ev(16, 2'b00, 2'b00, 2'b01, 2'b01);
    ev(18, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < stim.size(); i++) begin
      {aclr, key_n} = stim[i];
      tick();
      got = {press, rel, hold, level};
      if (sb.size() != 0 && sb[0].cyc == i) begin
        e = sb.pop_front(); lvl = e.level;
        want = {e.press, e.rel, e.hold, e.level};
      end else want = {6'b0, lvl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL release_bounce cyc=%0d prhl got=%b required=%b", i, got, want);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL release_bounce_pending got=%0d required=0", sb.size());
    end
  endtask

  // Long hold: hold pulse 10 cycles after press, optional auto-repeat.
  task automatic test_hold();
    logic [7:0] got, want;
    logic [1:0] lvl;
    exp_t       e;
    stim.delete(); sb.delete(); lvl = 2'b00;
    add_stim({1'b1, 2'b10}, 40);
    add_stim({1'b1, 2'b11}, 12);
    ev(6,  2'b01, 2'b00, 2'b00, 2'b01);
    ev(16, 2'b00, 2'b00, 2'b01, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = 19; t < 46; t += 3) ev(t, 2'b01, 2'b00, 2'b00, 2'b01);
`endif
    ev(46, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < stim.size(); i++) begin
      {aclr, key_n} = stim[i];
      tick();
      got = {press, rel, hold, level};
      if (sb.size() != 0 && sb[0].cyc == i) begin
        e = sb.pop_front(); lvl = e.level;
        want = {e.press, e.rel, e.hold, e.level};
      end else want = {6'b0, lvl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold cyc=%0d prhl got=%b required=%b", i, got, want);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL hold_pending got=%0d required=0", sb.size());
    end
  endtask

  // Both keys together, then reset during PRESS_WAIT discards the pending press.
  task automatic test_back_to_back();
    logic [7:0] got, want;
    logic [1:0] lvl;
    exp_t       e;
    stim.delete(); sb.delete(); lvl = 2'b00;
    add_stim({1'b1, 2'b11}, 1);
    add_stim({1'b1, 2'b00}, 8);
    add_stim({1'b1, 2'b11}, 12);
    add_stim({1'b1, 2'b00}, 4);
    add_stim({1'b0, 2'b00}, 2);
    add_stim({1'b1, 2'b00}, 8);
    add_stim({1'b1, 2'b11}, 12);
    ev(7,  2'b11, 2'b00, 2'b00, 2'b11);
    ev(15, 2'b00, 2'b11, 2'b00, 2'b00);
    ev(33, 2'b11, 2'b00, 2'b00, 2'b11);
    ev(41, 2'b00, 2'b11, 2'b00, 2'b00);
    for (int i = 0; i < stim.size(); i++) begin
      {aclr, key_n} = stim[i];
      tick();
      got = {press, rel, hold, level};
      if (sb.size() != 0 && sb[0].cyc == i) begin
        e = sb.pop_front(); lvl = e.level;
        want = {e.press, e.rel, e.hold, e.level};
      end else want = {6'b0, lvl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d prhl got=%b required=%b", i, got, want);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_pending got=%0d required=0", sb.size());
    end
  endtask

  initial begin
    aclr  = 1'b0;
    key_n = 2'b11;
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
